// File: rtl/io_mem_slave_if.sv
// io_mem_slave_if
//   IO request bus between the Spike-bridge transactor (master) and the
//   IO-space slave.
//
//   Handshake: the master raises io_req with io_wr/io_wen/io_addr/io_wdata
//   stable and holds all of them until a posedge where io_req_ack is also
//   high (the acceptance edge). The slave answers each accepted request
//   with exactly one single-cycle io_data_ack pulse carrying io_rdata and
//   io_err. Only one request is outstanding at a time.
//
//   Signals
//     io_req       master -> slave  request valid
//     io_wr        master -> slave  1 = write, 0 = read
//     io_wen[3:0]  master -> slave  write byte enables
//     io_addr      master -> slave  byte address
//     io_wdata     master -> slave  write data, lane i = bits [8i+7:8i]
//     io_req_ack   slave -> master  request accepted at this posedge
//     io_rdata     slave -> master  read data, zero outside io_data_ack
//     io_data_ack  slave -> master  completion pulse
//     io_err       slave -> master  error flag, qualified by io_data_ack
interface io_mem_slave_if;
    logic        io_req;
    logic        io_wr;
    logic [3:0]  io_wen;
    logic [31:0] io_addr;
    logic [31:0] io_wdata;
    logic        io_req_ack;
    logic [31:0] io_rdata;
    logic        io_data_ack;
    logic        io_err;

    modport master (
        output io_req, io_wr, io_wen, io_addr, io_wdata,
        input  io_req_ack, io_rdata, io_data_ack, io_err
    );

    modport slave (
        input  io_req, io_wr, io_wen, io_addr, io_wdata,
        output io_req_ack, io_rdata, io_data_ack, io_err
    );
endinterface

// File: rtl/io_mem_slave.sv
// io_mem_slave
//   Byte-addressed RAM terminating the IO request bus. One transaction at a
//   time, with REQ_WAIT accept wait-states and RSP_LAT cycles from the
//   acceptance edge to the io_data_ack pulse. Accesses are performed at the
//   acceptance edge; the response is only delayed.
//
//   Parameters
//     DEPTH_BYTES  RAM size in bytes, power of two, 16..4096
//     REQ_WAIT     cycles io_req is held before io_req_ack, 0..15
//     RSP_LAT      acceptance edge to io_data_ack, 1..15
//
//   Ports
//     clk        clock, all state on posedge
//     rst        asynchronous active-high reset
//     bus        io_mem_slave_if slave modport
//     dbg_state  current FSM state (0 = IDLE, 1 = WAIT_RSP)
module io_mem_slave #(
    parameter int DEPTH_BYTES = 256,
    parameter int REQ_WAIT    = 0,
    parameter int RSP_LAT     = 1
) (
    input  logic           clk,
    input  logic           rst,
    io_mem_slave_if.slave  bus,
    output logic [0:0]     dbg_state
);

    localparam int AW = $clog2(DEPTH_BYTES);
    localparam logic [3:0] REQ_WAIT_C = 4'(REQ_WAIT);
    localparam logic [3:0] RSP_LAT_C  = 4'(RSP_LAT);

    localparam logic [0:0] ST_IDLE     = 1'b0;
    localparam logic [0:0] ST_WAIT_RSP = 1'b1;

    logic [7:0]    mem [DEPTH_BYTES];

    logic [0:0]    state;
    logic [3:0]    wcnt;
    logic [3:0]    lcnt;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic          data_ack_q;
    logic [31:0]   rdata_q;
    logic          err_q;

    logic [AW-1:0] lane_addr [4];
    logic [31:0]   read_word;
    logic          acc_err;
    logic          req_ack;
    logic          accept;

    // Address bits between the RAM index and the region nibble are not decoded.
    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.io_addr[27:AW];

    // Byte lane i lives at idx+i; the AW-bit add wraps modulo DEPTH_BYTES.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            lane_addr[i] = bus.io_addr[AW-1:0] + AW'(i);
        end
    end

    always_comb begin
        read_word = '0;
        for (int i = 0; i < 4; i++) begin
            read_word[8*i +: 8] = mem[lane_addr[i]];
        end
    end

    // Region must be 0xF; writes must use a legal, naturally aligned enable.
    // Reads have no alignment restriction.
    always_comb begin
        acc_err = 1'b0;
        if (bus.io_addr[31:28] != 4'hF) begin
            acc_err = 1'b1;
        end
        if (bus.io_wr) begin
            case (bus.io_wen)
                4'b0001: ;
                4'b0011: if (bus.io_addr[0]) acc_err = 1'b1;
                4'b1111: if (bus.io_addr[1:0] != 2'b00) acc_err = 1'b1;
                default: acc_err = 1'b1;
            endcase
        end
    end

    // The FSM is already back in IDLE during the io_data_ack cycle, so a
    // request that has served its wait-states there is taken on the edge
    // that closes the pulse. Reset forces the ack low.
    assign req_ack = !rst && bus.io_req && (state == ST_IDLE) && (wcnt == REQ_WAIT_C);
    assign accept  = req_ack;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            wcnt       <= '0;
            lcnt       <= '0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
            data_ack_q <= 1'b0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            data_ack_q <= 1'b0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state     <= ST_WAIT_RSP;
                        lcnt      <= RSP_LAT_C;
                        wcnt      <= '0;
                        rsp_err   <= acc_err;
                        rsp_rdata <= (acc_err || bus.io_wr) ? 32'h0 : read_word;
                    end else if (!bus.io_req) begin
                        wcnt <= '0;
                    end else if (wcnt < REQ_WAIT_C) begin
                        wcnt <= wcnt + 4'd1;
                    end
                end
                ST_WAIT_RSP: begin
                    lcnt <= lcnt - 4'd1;
                    if (lcnt == 4'd1) begin
                        data_ack_q <= 1'b1;
                        rdata_q    <= rsp_rdata;
                        err_q      <= rsp_err;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // RAM array is not reset; writes commit at the acceptance edge.
    always_ff @(posedge clk) begin
        if (accept && bus.io_wr && !acc_err) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.io_wen[i]) begin
                    mem[lane_addr[i]] <= bus.io_wdata[8*i +: 8];
                end
            end
        end
    end

    assign bus.io_req_ack  = req_ack;
    assign bus.io_data_ack = data_ack_q;
    assign bus.io_rdata    = rdata_q;
    assign bus.io_err      = err_q;
    assign dbg_state       = state;

endmodule

// File: tb/tb_io_mem_slave.sv
module tb_io_mem_slave;
    localparam int DEPTH = 256;
    localparam int RW0 = 0;
    localparam int RL0 = 1;
    localparam int RW1 = 3;
    localparam int RL1 = 4;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // shared request drive, steered to one DUT by sel
    logic        sel;
    logic        req;
    logic        wr;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;

    io_mem_slave_if if0();
    io_mem_slave_if if1();

    assign if0.io_req   = req & ~sel;
    assign if0.io_wr    = wr;
    assign if0.io_wen   = wen;
    assign if0.io_addr  = addr;
    assign if0.io_wdata = wdata;
    assign if1.io_req   = req & sel;
    assign if1.io_wr    = wr;
    assign if1.io_wen   = wen;
    assign if1.io_addr  = addr;
    assign if1.io_wdata = wdata;

    logic [0:0] dbg0;
    logic [0:0] dbg1;

    io_mem_slave #(.DEPTH_BYTES(DEPTH), .REQ_WAIT(RW0), .RSP_LAT(RL0)) dut0 (
        .clk(clk), .rst(rst), .bus(if0), .dbg_state(dbg0)
    );
    io_mem_slave #(.DEPTH_BYTES(DEPTH), .REQ_WAIT(RW1), .RSP_LAT(RL1)) dut1 (
        .clk(clk), .rst(rst), .bus(if1), .dbg_state(dbg1)
    );

    logic        ack;
    logic        dack;
    logic        odack;
    logic [31:0] rdata;
    logic [31:0] ordata;
    logic        err;
    assign ack    = sel ? if1.io_req_ack  : if0.io_req_ack;
    assign dack   = sel ? if1.io_data_ack : if0.io_data_ack;
    assign odack  = sel ? if0.io_data_ack : if1.io_data_ack;
    assign rdata  = sel ? if1.io_rdata    : if0.io_rdata;
    assign ordata = sel ? if0.io_rdata    : if1.io_rdata;
    assign err    = sel ? if1.io_err      : if0.io_err;

    // scoreboard: {check_rdata, err, rdata, due_cycle}
    int total = 0;
    int bad   = 0;
    logic [65:0] exp_q[$];
    logic [65:0] e_mon;

    // reference RAM image per DUT
    logic [7:0] mdl [2][DEPTH];

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void model(input int d, input logic w, input logic [3:0] we,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  output logic [31:0] r, output logic e);
        int base;
        int b;
        e = (a[31:28] != 4'hF)
            || (w && !(we == 4'b0001 || we == 4'b0011 || we == 4'b1111))
            || (w && we == 4'b0011 && a[0])
            || (w && we == 4'b1111 && a[1:0] != 2'b00);
        r = 32'h0;
        base = int'(a % DEPTH);
        if (!e) begin
            for (int i = 0; i < 4; i++) begin
                b = (base + i) % DEPTH;
                if (w) begin
                    if (we[i]) mdl[d][b] = wd[8*i +: 8];
                end else begin
                    r[8*i +: 8] = mdl[d][b];
                end
            end
        end
    endfunction

    // driver: present request, wait for acceptance, push expected response
    task automatic issue(input int d, input logic w, input logic [3:0] we,
                         input logic [31:0] a, input logic [31:0] wd);
        int t0;
        int rwv;
        int rlv;
        bit got;
        logic [31:0] r;
        logic e;
        rwv = (d != 0) ? RW1 : RW0;
        rlv = (d != 0) ? RL1 : RL0;
        sel = (d != 0);
        wr = w; wen = we; addr = a; wdata = wd;
        req = 1'b1;
        t0 = cyc;
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (ack) begin
                got = 1'b1;
                check("req_ack_cycle", cyc - t0, rwv);
                model(d, w, we, a, wd, r, e);
                exp_q.push_back({(!w && !e), e, r, 32'(cyc + 1 + rlv)});
            end
        end
        if (!got) check("req_ack_timeout", 0, 1);
        @(posedge clk);
        #1;
        req = 1'b0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 60; k++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) break;
        end
        if (exp_q.size() != 0) begin
            check("rsp_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    task automatic txn(input int d, input logic w, input logic [3:0] we,
                       input logic [31:0] a, input logic [31:0] wd);
        issue(d, w, we, a, wd);
        wait_idle();
    endtask

    // monitor: pops and compares on every io_data_ack
    always @(negedge clk) begin
        if (!rst) begin
            if (odack) check("idle_dut_data_ack", 1, 0);
            if (ordata != 32'h0) check("idle_dut_rdata", ordata, 0);
            if (dack) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_data_ack", 1, 0);
                end else begin
                    e_mon = exp_q.pop_front();
                    check("data_ack_cycle", cyc, e_mon[31:0]);
                    check("err", {31'h0, err}, {31'h0, e_mon[64]});
                    if (e_mon[65]) check("rdata", rdata, e_mon[63:32]);
                end
            end else begin
                if (rdata != 32'h0) check("rdata_idle_zero", rdata, 0);
                if (err) check("err_idle_zero", 1, 0);
                if (exp_q.size() > 0 && cyc >= int'(exp_q[0][31:0])) begin
                    e_mon = exp_q.pop_front();
                    check("missing_data_ack", 0, 1);
                end
            end
        end
    end

    task automatic check_all_zero(string tag);
        check({tag, "_ack0"},   {31'h0, if0.io_req_ack},  0);
        check({tag, "_dack0"},  {31'h0, if0.io_data_ack}, 0);
        check({tag, "_rdata0"}, if0.io_rdata,             0);
        check({tag, "_err0"},   {31'h0, if0.io_err},      0);
        check({tag, "_ack1"},   {31'h0, if1.io_req_ack},  0);
        check({tag, "_dack1"},  {31'h0, if1.io_data_ack}, 0);
        check({tag, "_rdata1"}, if1.io_rdata,             0);
        check({tag, "_err1"},   {31'h0, if1.io_err},      0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        logic [3:0]  we;
        int d;

        sel = 1'b0; req = 1'b0; wr = 1'b0; wen = 4'h0; addr = 32'h0; wdata = 32'h0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        // request held during reset must not be acknowledged
        #1;
        req = 1'b1; addr = 32'hF000_0000;
        @(negedge clk);
        check_all_zero("reset");
        check("reset_state0", {31'h0, dbg0}, 0);
        check("reset_state1", {31'h0, dbg1}, 0);
        @(posedge clk);
        #1;
        req = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // fill both RAMs so every later read has a defined reference
        for (int dd = 0; dd < 2; dd++) begin
            for (int w = 0; w < DEPTH / 4; w++) begin
                txn(dd, 1'b1, 4'b1111, 32'hF000_0000 + 32'(w * 4), $urandom);
            end
        end

        // write/read round trip, zero wait-states
        txn(0, 1'b1, 4'b1111, 32'hF000_0010, 32'hDEAD_BEEF);
        txn(0, 1'b0, 4'b0000, 32'hF000_0010, 32'h0);

        // byte merge
        txn(0, 1'b1, 4'b1111, 32'hF000_0020, 32'h1122_3344);
        txn(0, 1'b1, 4'b0001, 32'hF000_0021, 32'h0000_00AA);
        txn(0, 1'b0, 4'b0000, 32'hF000_0020, 32'h0);
        txn(0, 1'b1, 4'b0011, 32'hF000_0022, 32'h0000_5566);
        txn(0, 1'b0, 4'b0000, 32'hF000_0020, 32'h0);

        // error cases: misaligned word, misaligned half, bad enable, bad region
        txn(0, 1'b1, 4'b1111, 32'hF000_0002, 32'h1234_5678);
        txn(0, 1'b0, 4'b0000, 32'hF000_0000, 32'h0);
        txn(0, 1'b1, 4'b0011, 32'hF000_0001, 32'h0000_9999);
        txn(0, 1'b1, 4'b0101, 32'hF000_0000, 32'h7777_7777);
        txn(0, 1'b0, 4'b0000, 32'hF000_0000, 32'h0);
        txn(0, 1'b0, 4'b0000, 32'h1000_0000, 32'h0);
        txn(0, 1'b1, 4'b0001, 32'h2000_0004, 32'h0000_0011);

        // wrap past the top of the RAM
        txn(0, 1'b1, 4'b0001, 32'hF000_0000, 32'h0000_00BE);
        txn(0, 1'b1, 4'b0001, 32'hF000_0001, 32'h0000_00BA);
        txn(0, 1'b1, 4'b1111, 32'hF000_00FC, 32'hCAFE_BABE);
        txn(0, 1'b0, 4'b0000, 32'hF000_00FE, 32'h0);
        txn(0, 1'b0, 4'b0000, 32'hF000_01FF, 32'h0);

        // wait-states and latency on the slow instance
        txn(1, 1'b1, 4'b1111, 32'hF000_0010, 32'hA5A5_0F0F);
        txn(1, 1'b0, 4'b0000, 32'hF000_0010, 32'h0);

        // request withdrawn one cycle short of acceptance: no access, wait restarts
        sel = 1'b1; wr = 1'b1; wen = 4'b1111; addr = 32'hF000_0040; wdata = 32'h5A5A_5A5A;
        req = 1'b1;
        for (int k = 0; k < RW1; k++) begin
            @(negedge clk);
            check("withdrawn_no_ack", {31'h0, ack}, 0);
        end
        @(posedge clk);
        #1;
        req = 1'b0;
        @(posedge clk);
        #1;
        txn(1, 1'b0, 4'b0000, 32'hF000_0040, 32'h0);

        // reset during a pending read: response dropped, next request normal
        txn(1, 1'b1, 4'b1111, 32'hF000_0050, 32'h0BAD_F00D);
        issue(1, 1'b0, 4'b0000, 32'hF000_0050, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check_all_zero("midrst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        txn(1, 1'b0, 4'b0000, 32'hF000_0050, 32'h0);

        // reset during a pending write: data stays committed
        issue(1, 1'b1, 4'b1111, 32'hF000_0060, 32'h1357_9BDF);
        #1;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        txn(1, 1'b0, 4'b0000, 32'hF000_0060, 32'h0);

        // randomized traffic on both instances
        for (int n = 0; n < 300; n++) begin
            d = int'($urandom_range(0, 1));
            a = $urandom;
            if ($urandom_range(0, 9) != 0) a[31:28] = 4'hF;
            if ($urandom_range(0, 2) == 0) a[1:0] = 2'b00;
            case ($urandom_range(0, 6))
                0, 1:    we = 4'b0001;
                2, 3:    we = 4'b0011;
                4, 5:    we = 4'b1111;
                default: we = 4'($urandom_range(0, 15));
            endcase
            txn(d, 1'($urandom_range(0, 1)), we, a, $urandom);
        end

        repeat (4) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
